bp_cac_edge_gate: RTL and testbench
===================================

// Module: bp_cac_edge_gate
// PURPOSE
//  Packet-aware isolation gate between the coherence mesh west edge and the accelerator complex columns.
//  Covers nets_p networks (req/cmd/resp) x rows_p rows, both directions, each lane buffered by a 2-entry FIFO.
//  Drains in-flight wormhole packets, then isolates accelerators at run time without corrupting the mesh.
//  Generalises the static all-or-nothing accelerator-complex stub.
// PARAMETERS
//  nets_p        3    coherence networks gated (req, cmd, resp)
//  rows_p        1    accelerator rows (cac_y_dim_p)
//  flit_width_p  64   coh_noc_flit_width_p
//  len_width_p   4    header length field width: body flits following the header
//  len_offset_p  0    LSB position of the length field in a header flit
//  cnt_width_p   16   dropped-packet counter width
//  ral_lp = flit_width_p+2 (localparam; v + data + ready_and)
// PORTS
//  coh_clk_i      in   1                     single clock
//  coh_reset_n_i  in   1                     asynchronous, active-low reset
//  isolate_i      in   1                     level request: 1 = isolate accelerators
//  mesh_link_i    in   nets_p*rows_p*ral_lp  ready-and links from the mesh edge
//  mesh_link_o    out  nets_p*rows_p*ral_lp  ready-and links to the mesh edge
//  accel_link_i   in   nets_p*rows_p*ral_lp  ready-and links from accelerator tiles
//  accel_link_o   out  nets_p*rows_p*ral_lp  ready-and links to accelerator tiles
//  state_o        out  2                     gate state (bp_cac_gate_state_e)
//  drop_count_o   out  cnt_width_p           mesh->accel packets discarded while closed
// BEHAVIOUR
//  Reset: FIFOs empty; trackers idle; state e_closed; all link v and ready_and 0; drop_count_o 0.
//  Lane = one direction of one (net,row): 2-entry FIFO plus packet tracker.
//  - Enqueue on v & ready_and. Dequeue on v & downstream ready_and. Latency is 1 cycle. Full FIFO deasserts ready_and.
//  - Simultaneous enq/deq on a full FIFO is allowed (full throughput).
//  - Tracker: on an idle header accept, load rem = hdr[len_offset_p+:len_width_p]. rem==0 keeps the tracker idle.
//  - Each body accept decrements rem; busy until rem reaches 0. rem never underflows.
//  - Trackers count on the FIFO input side.
//  States:
//  - e_open: all lanes pass traffic.
//  - e_drain: entered from e_open when isolate_i=1. Idle trackers hold ready_and=0 (no new headers). Busy lanes finish their packets.
//    -> e_closed when every tracker is idle and every FIFO is empty.
//    -> e_open when isolate_i=0 (allowed, because no header was split).
//  - e_closed:
//    - accel_link_o v=0.
//    - accel_link_o ready_and=0: accelerators are back-pressured.
//    - mesh_link_o v=0.
//    - mesh_link_o ready_and=1: mesh->accel flits are accepted and discarded per packet, never entering a FIFO.
//    - The drop counter increments once per discarded header and saturates at all-ones.
//    -> e_open when isolate_i=0 and every discard tracker is idle.
//    -> otherwise stays, finishing the discard of the current packet.
//  - Reset mid-packet: all state is cleared. Partial packets are lost; this is accepted behaviour.
//  - Simultaneous header accept and the transition into e_drain: the header is accepted and its packet drains.
//  state_o encoding: 0 open, 1 drain, 2 closed.
// CONFIGURATION
//  BP_CAC_EDGE_GATE_DROP_CNT_EN defined: the saturating drop counter is implemented as above.
//  BP_CAC_EDGE_GATE_DROP_CNT_EN undefined: no counter; drop_count_o tied 0; discard behaviour unchanged.
// STRUCTURE
//  bp_common_pkg: typedef enum logic [1:0] bp_cac_gate_state_e {e_open, e_drain, e_closed}.
//  Links use declare_bsg_ready_and_link_sif_s(flit_width_p, ...).
//  Sub-module bp_cac_edge_lane (FIFO, tracker, gate_i, discard_i; outputs idle_o, empty_o, hdr_drop_o).
//  Instantiated 2*nets_p*rows_p times. The top holds the FSM, AND-reduction and counter.
// TESTING
//  1 Reset released, isolate_i=0 -> e_closed for 1 cycle, then e_open. 3-flit packet (len=2) mesh->accel arrives 1 cycle later.
//  2 isolate_i=1 after flit 1 of a len=3 packet -> flits 2..4 delivered; next header stalled (ready_and=0); e_closed after FIFO empty.
//  3 e_closed, 5 single-flit and 2 len=1 packets from the mesh -> all accepted, accel v=0, drop_count_o=7 (0 without macro).
//  4 isolate_i=0 while discarding body flit 1 of a len=3 packet -> stays e_closed until the last body flit, then e_open; next packet delivered.
//  5 Full FIFO with sink ready_and=0 for 10 cycles, then 1 -> no loss, no duplication, order preserved, 1 flit/cycle.
//  6 cnt_width_p=3, 9 dropped packets -> drop_count_o saturates at 7; async reset mid-test -> all outputs 0 immediately.

Source files
------------

// File: rtl/bp_common_pkg.sv
// rtl/bp_common_pkg.sv - shared types for the accelerator-complex edge gate
package bp_common_pkg;

  typedef enum logic [1:0] {
    e_open   = 2'd0,
    e_drain  = 2'd1,
    e_closed = 2'd2
  } bp_cac_gate_state_e;

endpackage

// File: rtl/bp_cac_edge_lane.sv
// rtl/bp_cac_edge_lane.sv - one gated lane: 2-entry FIFO plus wormhole packet tracker
module bp_cac_edge_lane #(
  parameter int flit_width_p = 64,
  parameter int len_width_p  = 4,
  parameter int len_offset_p = 0
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    gate_i,
  input  logic                    discard_i,
  input  logic                    in_v_i,
  input  logic [flit_width_p-1:0] in_data_i,
  output logic                    in_ready_and_o,
  output logic                    out_v_o,
  output logic [flit_width_p-1:0] out_data_o,
  input  logic                    out_ready_and_i,
  output logic                    idle_o,
  output logic                    empty_o,
  output logic                    hdr_drop_o
);

  logic [flit_width_p-1:0] mem_q [2];
  logic [flit_width_p-1:0] mem_d [2];
  logic                    wr_ptr_q, wr_ptr_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic [1:0]              count_q, count_d;
  logic [len_width_p-1:0]  rem_q, rem_d;
  logic                    full, accept, enq, deq;

  // Handshakes, FIFO bookkeeping and body-flit countdown; while discarding, accepted flits bypass the FIFO.
  always_comb begin
    full           = (count_q == 2'd2);
    empty_o        = (count_q == 2'd0);
    idle_o         = (rem_q == '0);
    // An idle tracker only admits a new header while the gate is open; a busy one always finishes its packet.
    in_ready_and_o = discard_i | (~full & (gate_i | ~idle_o));
    accept         = in_v_i & in_ready_and_o;
    enq            = accept & ~discard_i;
    deq            = ~empty_o & out_ready_and_i;
    out_v_o        = ~empty_o;
    out_data_o     = mem_q[rd_ptr_q];
    hdr_drop_o     = accept & discard_i & idle_o;

    mem_d = mem_q;
    if (enq) mem_d[wr_ptr_q] = in_data_i;
    wr_ptr_d = wr_ptr_q ^ enq;
    rd_ptr_d = rd_ptr_q ^ deq;
    count_d  = count_q + 2'(enq) - 2'(deq);

    rem_d = rem_q;
    if (accept) begin
      if (idle_o) rem_d = in_data_i[len_offset_p +: len_width_p];
      else        rem_d = rem_q - len_width_p'(1);
    end
  end

  // Lane state register; reset drops any partial packet.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      rem_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rem_q    <= rem_d;
    end
  end

endmodule

// File: rtl/bp_cac_edge_gate.sv
// rtl/bp_cac_edge_gate.sv - packet-aware mesh/accelerator isolation gate; BP_CAC_EDGE_GATE_DROP_CNT_EN enables the drop counter
module bp_cac_edge_gate
  import bp_common_pkg::*;
#(
  parameter int nets_p       = 3,
  parameter int rows_p       = 1,
  parameter int flit_width_p = 64,
  parameter int len_width_p  = 4,
  parameter int len_offset_p = 0,
  parameter int cnt_width_p  = 16,
  localparam int ral_lp      = flit_width_p + 2,
  localparam int lanes_lp    = nets_p * rows_p
) (
  input  logic                         coh_clk_i,
  input  logic                         coh_reset_n_i,
  input  logic                         isolate_i,
  input  logic [lanes_lp*ral_lp-1:0]   mesh_link_i,
  output logic [lanes_lp*ral_lp-1:0]   mesh_link_o,
  input  logic [lanes_lp*ral_lp-1:0]   accel_link_i,
  output logic [lanes_lp*ral_lp-1:0]   accel_link_o,
  output logic [1:0]                   state_o,
  output logic [cnt_width_p-1:0]       drop_count_o
);

  bp_cac_gate_state_e state_q, state_d;
  logic               alive_q, alive_d;
  logic               gate, discard, all_idle, all_empty;

  logic [lanes_lp-1:0] m2a_in_ready, m2a_out_v, m2a_idle, m2a_empty, m2a_hdr_drop;
  logic [lanes_lp-1:0] a2m_in_ready, a2m_out_v, a2m_idle, a2m_empty, a2m_hdr_drop;
  logic [flit_width_p-1:0] m2a_out_data [lanes_lp];
  logic [flit_width_p-1:0] a2m_out_data [lanes_lp];

  for (genvar l = 0; l < lanes_lp; l++) begin : g_lane
    localparam int base_lp = l * ral_lp;

    bp_cac_edge_lane #(
      .flit_width_p(flit_width_p), .len_width_p(len_width_p), .len_offset_p(len_offset_p)
    ) m2a (
      .clk_i(coh_clk_i), .reset_n_i(coh_reset_n_i), .gate_i(gate), .discard_i(discard),
      .in_v_i(mesh_link_i[base_lp+ral_lp-1]), .in_data_i(mesh_link_i[base_lp+1 +: flit_width_p]),
      .in_ready_and_o(m2a_in_ready[l]),
      .out_v_o(m2a_out_v[l]), .out_data_o(m2a_out_data[l]), .out_ready_and_i(accel_link_i[base_lp]),
      .idle_o(m2a_idle[l]), .empty_o(m2a_empty[l]), .hdr_drop_o(m2a_hdr_drop[l])
    );

    // Accelerators are never discarded, only back-pressured while closed.
    bp_cac_edge_lane #(
      .flit_width_p(flit_width_p), .len_width_p(len_width_p), .len_offset_p(len_offset_p)
    ) a2m (
      .clk_i(coh_clk_i), .reset_n_i(coh_reset_n_i), .gate_i(gate), .discard_i(1'b0),
      .in_v_i(accel_link_i[base_lp+ral_lp-1]), .in_data_i(accel_link_i[base_lp+1 +: flit_width_p]),
      .in_ready_and_o(a2m_in_ready[l]),
      .out_v_o(a2m_out_v[l]), .out_data_o(a2m_out_data[l]), .out_ready_and_i(mesh_link_i[base_lp]),
      .idle_o(a2m_idle[l]), .empty_o(a2m_empty[l]), .hdr_drop_o(a2m_hdr_drop[l])
    );

    assign mesh_link_o[base_lp +: ral_lp]  = {a2m_out_v[l], a2m_out_data[l], m2a_in_ready[l]};
    assign accel_link_o[base_lp +: ral_lp] = {m2a_out_v[l], m2a_out_data[l], a2m_in_ready[l]};
  end

  // Gate FSM: drain whole packets before closing, and reopen only between discarded packets.
  always_comb begin
    all_idle  = (&m2a_idle) & (&a2m_idle);
    all_empty = (&m2a_empty) & (&a2m_empty);
    state_d   = state_q;
    alive_d   = 1'b1;
    unique case (state_q)
      e_open:   if (isolate_i) state_d = e_drain;
      e_drain: begin
        if (!isolate_i)                 state_d = e_open;
        else if (all_idle && all_empty) state_d = e_closed;
      end
      e_closed: if (!isolate_i && all_idle) state_d = e_open;
      default:  state_d = e_closed;
    endcase
    gate    = (state_q == e_open);
    // Discard (and its ready_and=1) waits one cycle out of reset so links stay quiet during reset.
    discard = (state_q == e_closed) & alive_q;
  end

  // Gate state register.
  always_ff @(posedge coh_clk_i or negedge coh_reset_n_i) begin
    if (!coh_reset_n_i) begin
      state_q <= e_closed;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      alive_q <= alive_d;
    end
  end

  assign state_o = state_q;

`ifdef BP_CAC_EDGE_GATE_DROP_CNT_EN
  logic [cnt_width_p-1:0] drop_cnt_q, drop_cnt_d;
  logic                   unused_hdr_drop;

  // Count every discarded header across lanes, saturating at all-ones.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    for (int i = 0; i < lanes_lp; i++) begin
      if (m2a_hdr_drop[i] && (drop_cnt_d != '1)) drop_cnt_d = drop_cnt_d + cnt_width_p'(1);
    end
  end

  // Drop counter register.
  always_ff @(posedge coh_clk_i or negedge coh_reset_n_i) begin
    if (!coh_reset_n_i) drop_cnt_q <= '0;
    else                drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count_o    = drop_cnt_q;
  assign unused_hdr_drop = |a2m_hdr_drop;
`else
  logic unused_hdr_drop;
  assign drop_count_o    = '0;
  assign unused_hdr_drop = |{a2m_hdr_drop, m2a_hdr_drop};
`endif

endmodule

// File: tb/tb_bp_cac_edge_gate.sv
// tb/tb_bp_cac_edge_gate.sv - directed vector bench for bp_cac_edge_gate
module tb_bp_cac_edge_gate;

  localparam int NETS = 3;
  localparam int FW   = 16;
  localparam int RAL  = FW + 2;
  localparam int W    = NETS * RAL;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         isolate = 1'b0;
  logic [W-1:0] mesh_link_i = '0;
  logic [W-1:0] mesh_link_o;
  logic [W-1:0] accel_link_i = '0;
  logic [W-1:0] accel_link_o;
  logic [1:0]   state_o;
  logic [2:0]   drop_count_o;

  int vectors = 0;
  int miscompares = 0;

  bp_cac_edge_gate #(
    .nets_p(NETS), .rows_p(1), .flit_width_p(FW), .len_width_p(4),
    .len_offset_p(0), .cnt_width_p(3)
  ) dut (
    .coh_clk_i(clk), .coh_reset_n_i(rst_n), .isolate_i(isolate),
    .mesh_link_i(mesh_link_i), .mesh_link_o(mesh_link_o),
    .accel_link_i(accel_link_i), .accel_link_o(accel_link_o),
    .state_o(state_o), .drop_count_o(drop_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iso;
    logic        mv;
    logic [15:0] md;
    logic        ar;
    logic [1:0]  st;
    logic        mr;
    logic        av;
    logic [15:0] ad;
    int          dc;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] exp_dc(input int n);
`ifdef BP_CAC_EDGE_GATE_DROP_CNT_EN
    return 32'(n);
`else
    return (n > 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic add(input logic iso, input logic mv, input logic [15:0] md, input logic ar,
                     input logic [1:0] st, input logic mr, input logic av, input logic [15:0] ad,
                     input int dc);
    vec_t v;
    v.iso = iso; v.mv = mv; v.md = md; v.ar = ar;
    v.st = st; v.mr = mr; v.av = av; v.ad = ad; v.dc = dc;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic iso, input logic mv, input logic [15:0] md, input logic ar);
    isolate = iso;
    mesh_link_i = '0;
    accel_link_i = '0;
    for (int l = 0; l < NETS; l++) begin
      mesh_link_i[l*RAL]  = 1'b1;
      accel_link_i[l*RAL] = 1'b1;
    end
    mesh_link_i[RAL-1]  = mv;
    mesh_link_i[FW:1]   = md;
    accel_link_i[0]     = ar;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  initial begin
    // Test 1: open and a len=2 packet mesh->accel
    add(0,0,16'h0000,1, 2,0,0,16'h0000,0);
    add(0,1,16'h1002,1, 0,1,0,16'h0000,0);
    add(0,1,16'h1010,1, 0,1,1,16'h1002,0);
    add(0,1,16'h1020,1, 0,1,1,16'h1010,0);
    add(0,0,16'h0000,1, 0,1,1,16'h1020,0);
    add(0,0,16'h0000,1, 0,1,0,16'h0000,0);
    // Test 2: header accepted on the cycle isolate rises, packet drains, next header stalls
    add(1,1,16'h2003,1, 0,1,0,16'h0000,0);
    add(1,1,16'h2010,1, 1,1,1,16'h2003,0);
    add(1,1,16'h2020,1, 1,1,1,16'h2010,0);
    add(1,1,16'h2030,1, 1,1,1,16'h2020,0);
    add(1,1,16'h3001,1, 1,0,1,16'h2030,0);
    add(1,1,16'h3001,1, 1,0,0,16'h0000,0);
    // Test 3: closed, two len=1 packets and five single flits discarded
    add(1,1,16'h3001,1, 2,1,0,16'h0000,0);
    add(1,1,16'h3010,1, 2,1,0,16'h0000,1);
    add(1,1,16'h4001,1, 2,1,0,16'h0000,1);
    add(1,1,16'h4010,1, 2,1,0,16'h0000,2);
    for (int i = 0; i < 5; i++) add(1,1,16'h5000 + 16'(i*256),1, 2,1,0,16'h0000,2+i);
    add(1,0,16'h0000,1, 2,1,0,16'h0000,7);
    // Test 4: release mid-discard, reopen only after the last body flit
    add(1,1,16'h6003,1, 2,1,0,16'h0000,7);
    add(0,1,16'h6010,1, 2,1,0,16'h0000,7);
    add(0,1,16'h6020,1, 2,1,0,16'h0000,7);
    add(0,1,16'h6030,1, 2,1,0,16'h0000,7);
    add(0,0,16'h0000,1, 2,1,0,16'h0000,7);
    add(0,1,16'h7001,1, 0,1,0,16'h0000,7);
    add(0,1,16'h7010,1, 0,1,1,16'h7001,7);
    add(0,0,16'h0000,1, 0,1,1,16'h7010,7);
    add(0,0,16'h0000,1, 0,1,0,16'h0000,7);
    // Test 5: sink stalls 10 cycles on a full FIFO, then streams
    add(0,1,16'h8003,0, 0,1,0,16'h0000,7);
    add(0,1,16'h8010,0, 0,1,1,16'h8003,7);
    for (int i = 0; i < 8; i++) add(0,1,16'h8020,0, 0,0,1,16'h8003,7);
    add(0,1,16'h8020,1, 0,0,1,16'h8003,7);
    add(0,1,16'h8020,1, 0,1,1,16'h8010,7);
    add(0,1,16'h8030,1, 0,1,1,16'h8020,7);
    add(0,0,16'h0000,1, 0,1,1,16'h8030,7);
    add(0,0,16'h0000,1, 0,1,0,16'h0000,7);

    drive(0, 0, 16'h0000, 1);
    @(negedge clk);
    @(negedge clk);
    vectors++;
    chk("reset state", 32'(state_o), 32'd2);
    chk("reset mesh_link_o", 32'(|mesh_link_o), 32'd0);
    chk("reset accel_link_o", 32'(|accel_link_o), 32'd0);
    chk("reset drop_count", 32'(drop_count_o), 32'd0);
    rst_n = 1'b1;

    for (int r = 0; r < tbl.size(); r++) begin
      drive(tbl[r].iso, tbl[r].mv, tbl[r].md, tbl[r].ar);
      #1;
      vectors++;
      chk($sformatf("r%0d state", r), 32'(state_o), 32'(tbl[r].st));
      chk($sformatf("r%0d mesh ready", r), 32'(mesh_link_o[0]), 32'(tbl[r].mr));
      chk($sformatf("r%0d accel v", r), 32'(accel_link_o[RAL-1]), 32'(tbl[r].av));
      if (tbl[r].av) chk($sformatf("r%0d accel data", r), 32'(accel_link_o[FW:1]), 32'(tbl[r].ad));
      chk($sformatf("r%0d accel ready", r), 32'(accel_link_o[0]), (tbl[r].st == 2'd0) ? 32'd1 : 32'd0);
      chk($sformatf("r%0d mesh v", r), 32'(mesh_link_o[RAL-1]), 32'd0);
      chk($sformatf("r%0d drop count", r), 32'(drop_count_o), exp_dc(tbl[r].dc));
      @(negedge clk);
    end

    // accel->mesh delivery on net 1
    drive(0, 0, 16'h0000, 1);
    accel_link_i[2*RAL-1] = 1'b1;
    accel_link_i[RAL+FW:RAL+1] = 16'h9000;
    #1;
    vectors++;
    chk("a2m ready", 32'(accel_link_o[RAL]), 32'd1);
    @(negedge clk);
    drive(0, 0, 16'h0000, 1);
    #1;
    vectors++;
    chk("a2m mesh v", 32'(mesh_link_o[2*RAL-1]), 32'd1);
    chk("a2m mesh data", 32'(mesh_link_o[RAL+FW:RAL+1]), 32'h9000);
    @(negedge clk);
    #1;
    vectors++;
    chk("a2m mesh v after", 32'(mesh_link_o[2*RAL-1]), 32'd0);

    // Test 6: saturation after reset, closed from the start
    @(negedge clk);
    rst_n = 1'b0;
    drive(1, 0, 16'h0000, 1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    chk("t6 state", 32'(state_o), 32'd2);
    chk("t6 first-cycle ready", 32'(mesh_link_o[0]), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      drive(1, (i < 9), 16'hA000 | 16'(i << 4), 1);
      #1;
      vectors++;
      chk($sformatf("t6 i%0d ready", i), 32'(mesh_link_o[0]), 32'd1);
      chk($sformatf("t6 i%0d drop count", i), 32'(drop_count_o), exp_dc((i < 7) ? i : 7));
      @(negedge clk);
    end

    // asynchronous reset in the middle of a discarded packet
    drive(1, 1, 16'hB003, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    vectors++;
    chk("async rst mesh_link_o", 32'(|mesh_link_o), 32'd0);
    chk("async rst accel_link_o", 32'(|accel_link_o), 32'd0);
    chk("async rst drop_count", 32'(drop_count_o), 32'd0);
    chk("async rst state", 32'(state_o), 32'd2);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 16'h0000, 1);
    @(negedge clk);
    #1;
    vectors++;
    chk("post rst state", 32'(state_o), 32'd0);
    chk("post rst mesh ready", 32'(mesh_link_o[0]), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
